pipe_stage_reg: RTL and testbench

- Parametrised elastic pipeline register; the generic successor of the fixed ID/EXE latch.
- Carries a data bundle (operands, immediates, PC+4) and a control bundle (write-enable, mem-write, ALU control, etc.) between any two pipeline stages.
- Uses valid/ready handshake, a flush input that turns the held instruction into a bubble, and a saturating bubble counter for performance monitoring.
- Instantiated per stage boundary (IF/ID, ID/EXE, EXE/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_skid_buf.sv | 54 +++++
 rtl/pipe_stage_reg.sv | 133 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths and control-bundle layout for the elastic pipeline stage registers.
package pipe_pkg;

  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_CTRL_W = 16;
  localparam int PIPE_CNT_W  = 16;

  // Bit positions inside the control bundle
  localparam int CTRL_WREG_BIT   = 0;
  localparam int CTRL_M2REG_BIT  = 1;
  localparam int CTRL_WMEM_BIT   = 2;
  localparam int CTRL_ALUIMM_BIT = 3;
  localparam int CTRL_SHIFT_BIT  = 4;
  localparam int CTRL_JAL_BIT    = 5;
  localparam int CTRL_ALUC_LSB   = 6;
  localparam int CTRL_ALUC_MSB   = 9;

  localparam logic [PIPE_CTRL_W-1:0] PIPE_NOP_CTRL = '0;

  // True when a control word can change architectural state.
  function automatic logic ctrl_has_side_effect(input logic [PIPE_CTRL_W-1:0] c);
    return c[CTRL_WREG_BIT] | c[CTRL_WMEM_BIT];
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Second (overflow) entry of the elastic stage register; used only when
// PIPE_STAGE_SKID_EN is defined.
module pipe_skid_buf #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  input  logic [CTRL_W-1:0] push_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (push) begin
      valid_d = 1'b1;
      data_d  = push_data;
      ctrl_d  = push_ctrl;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with flush and a saturating bubble counter.
// Define PIPE_STAGE_SKID_EN for a two-entry build with a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt,
  input  logic              cnt_clr
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds its bundle until then.
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              skid_push, skid_pop;

  // Ready depends only on a flop, so out_ready never reaches upstream.
  assign in_ready  = !skid_valid;
  assign skid_push = in_xfer & out_valid_q & !out_ready & !flush;
  assign skid_pop  = out_xfer & skid_valid & !flush;

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk       (clk),
    .clrn      (clrn),
    .flush     (flush),
    .push      (skid_push),
    .pop       (skid_pop),
    .push_data (in_data),
    .push_ctrl (in_ctrl),
    .valid     (skid_valid),
    .data      (skid_data),
    .ctrl      (skid_ctrl)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
    end else if (skid_pop) begin
      out_valid_d = 1'b1;
      out_data_d  = skid_data;
      out_ctrl_d  = skid_ctrl;
    end else if (in_xfer && (!out_valid_q || out_ready)) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_ctrl_d  = in_ctrl;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
    end
  end
`else
  assign in_ready = !out_valid_q | out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
    end else if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_ctrl_d  = in_ctrl;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
    end
  end
`endif

  // Clear wins over increment; the count sticks at all-ones.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr) begin
      bubble_cnt_d = '0;
    end else if (!out_valid_q && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ctrl_q   <= '0;
      bubble_cnt_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ctrl_q   <= out_ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ctrl   = out_ctrl_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random bench for pipe_stage_reg with a FIFO scoreboard of
// accepted bundles and a reference bubble counter.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DATA_W = 128;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              clrn;
  logic              in_valid, in_ready, flush, out_valid, out_ready, cnt_clr;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  // Narrow-counter instance, kept idle to exercise saturation.
  logic              d3_in_ready, d3_out_valid;
  logic [DATA_W-1:0] d3_out_data;
  logic [CTRL_W-1:0] d3_out_ctrl;
  logic [2:0]        d3_cnt;
  logic              d3_cnt_clr = 1'b0;

  logic [DATA_W+CTRL_W-1:0] exp_q[$];
  logic [CNT_W-1:0]         exp_cnt;
  logic [2:0]               exp_cnt3;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) u_dut (
    .clk (clk), .clrn (clrn), .in_valid (in_valid), .in_ready (in_ready),
    .in_data (in_data), .in_ctrl (in_ctrl), .flush (flush), .out_valid (out_valid),
    .out_ready (out_ready), .out_data (out_data), .out_ctrl (out_ctrl),
    .bubble_cnt (bubble_cnt), .cnt_clr (cnt_clr)
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(3)) u_dut3 (
    .clk (clk), .clrn (clrn), .in_valid (1'b0), .in_ready (d3_in_ready),
    .in_data ('0), .in_ctrl ('0), .flush (1'b0), .out_valid (d3_out_valid),
    .out_ready (1'b1), .out_data (d3_out_data), .out_ctrl (d3_out_ctrl),
    .bubble_cnt (d3_cnt), .cnt_clr (d3_cnt_clr)
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check shortly after, then update
  // the reference model for what the next rising edge does.
  task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                      input logic ordy, input logic fl, input logic clr, output logic acc);
    logic exp_rdy;
    logic [DATA_W+CTRL_W-1:0] head;
    logic was_empty;
    in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl; cnt_clr = clr;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    exp_rdy = (exp_q.size() < 2);
`else
    exp_rdy = (exp_q.size() == 0) || ordy;
`endif
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("out_data", out_data, head[DATA_W+CTRL_W-1:CTRL_W]);
      check("out_ctrl", out_ctrl, head[CTRL_W-1:0]);
    end else begin
      check("out_ctrl_bubble", out_ctrl, '0);
    end
    check("bubble_cnt", bubble_cnt, exp_cnt);
    check("bubble_cnt3", d3_cnt, exp_cnt3);
    was_empty = (exp_q.size() == 0);
    if (clr) exp_cnt = '0;
    else if (was_empty && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    if (exp_cnt3 != 3'd7) exp_cnt3 = exp_cnt3 + 3'd1;
    if (!was_empty && ordy) void'(exp_q.pop_front());
    if (fl) exp_q.delete();
    else if (iv && exp_rdy) exp_q.push_back({d, c});
    acc = iv && exp_rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    logic [DATA_W-1:0] nxt;
    clrn = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    exp_cnt = '0; exp_cnt3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_ctrl", out_ctrl, '0);
    check("rst_bubble_cnt", bubble_cnt, '0);
    clrn = 1'b1;

    // Idle, then bubble gating with a fully set control word.
    repeat (5) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    check("idle5_cnt", bubble_cnt, 16'd5);
    repeat (2) step(1'b0, 128'hdead, 16'hFFFF, 1'b1, 1'b0, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, acc);
    check("cnt_clr_with_bubble", bubble_cnt, '0);
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    check("cnt3_saturated", d3_cnt, 3'd7);

    // Streaming 0x1..0x8 at full rate.
    for (int i = 1; i <= 8; i++)
      step(1'b1, DATA_W'(i), CTRL_W'(i) | CTRL_W'(1 << CTRL_WREG_BIT), 1'b1, 1'b0, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

    // Backpressure for 3 cycles, then drain; data advances only when accepted.
    nxt = 128'h10;
    repeat (3) begin
      step(1'b1, nxt, 16'h0100 | nxt[15:0], 1'b0, 1'b0, 1'b0, acc);
      if (acc) nxt = nxt + 1;
    end
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

    // Flush kills both the held and the incoming entry.
    step(1'b1, 128'h20, 16'h0022, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 128'h21, 16'h0011, 1'b0, 1'b1, 1'b0, acc);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_out_ctrl", out_ctrl, '0);
    repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

    // Asynchronous reset while holding a valid entry.
    step(1'b1, 128'h30, 16'h0033, 1'b0, 1'b0, 1'b0, acc);
    clrn = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_ctrl", out_ctrl, '0);
    check("midrst_bubble_cnt", bubble_cnt, '0);
    exp_q.delete(); exp_cnt = '0; exp_cnt3 = '0;
    @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);

    // Random traffic with occasional flush and counter clear.
    nxt = 128'h100;
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), nxt, 16'($urandom_range(0, 16'hFFFF)),
           1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0, acc);
      if (acc) nxt = nxt + 1;
    end
    repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
